// File: rtl/rf_write_arbiter_pkg.sv
// ============================================================================
// rf_write_arbiter_pkg : shared CPU register-file constants and write types
// Revision: 1.0
// ============================================================================
`default_nettype none

package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

  // r0 is hardwired to zero, so writes to it are never real writes.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_write_arbiter_wb_fifo.sv
// ============================================================================
// wb_fifo : synchronous FIFO of {addr, data} secondary writes with per-slot
//           address match used for register busy tracking
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0]     head_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [REG_ADDR_W-1:0] match_addr_1_i,
  input  logic [REG_ADDR_W-1:0] match_addr_2_i,
  output logic                  match_1_o,
  output logic                  match_2_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rf_wr_t             mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               push_ok;
  logic               pop_ok;
  logic [DEPTH-1:0]   hit_1;
  logic [DEPTH-1:0]   hit_2;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign head_addr_o = mem_q[rd_ptr_q].addr;
  assign head_data_o = mem_q[rd_ptr_q].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q].addr <= push_addr_i;
      mem_q[wr_ptr_q].data <= push_data_i;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot_match
    assign hit_1[i] = valid_q[i] & (mem_q[i].addr == match_addr_1_i);
    assign hit_2[i] = valid_q[i] & (mem_q[i].addr == match_addr_2_i);
  end

  assign match_1_o = |hit_1;
  assign match_2_o = |hit_2;

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// rf_write_arbiter : merges pipeline WB writes and buffered secondary writes
//                    onto the single register-file write port
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  ext_valid_i,
  output logic                  ext_ready_o,
  input  logic [REG_ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0]     ext_data_i,
  output logic                  stall_req_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  input  logic [REG_ADDR_W-1:0] chk_addr_1_i,
  input  logic [REG_ADDR_W-1:0] chk_addr_2_i,
  output logic                  chk_busy_1_o,
  output logic                  chk_busy_2_o
);

  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

  logic [SCNT_W-1:0]     starve_q;
  logic [SCNT_W-1:0]     starve_d;
  logic                  stall_q;
  logic                  stall_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0]     head_data;
  logic                  hit_1;
  logic                  hit_2;
  logic                  push;
  logic                  pop;

  // Ready comes only from registered occupancy: no path from ext_valid_i.
  assign ext_ready_o = ~reset & ~fifo_full;
  assign push        = ext_valid_i & ext_ready_o & is_real_reg(ext_addr_i);
  assign pop         = ~reset & ~wb_valid_i & ~fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (push),
    .push_addr_i    (ext_addr_i),
    .push_data_i    (ext_data_i),
    .pop_i          (pop),
    .head_addr_o    (head_addr),
    .head_data_o    (head_data),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .match_addr_1_i (chk_addr_1_i),
    .match_addr_2_i (chk_addr_2_i),
    .match_1_o      (hit_1),
    .match_2_o      (hit_2)
  );

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (!reset) begin
      if (wb_valid_i) begin
        rf_we_o    = is_real_reg(wb_addr_i);
        rf_waddr_o = wb_addr_i;
        rf_wdata_o = wb_data_i;
      end else if (!fifo_empty) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = head_addr;
        rf_wdata_o = head_data;
      end
    end
  end

  // Count cycles in which a queued entry lost its slot to WB.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (wb_valid_i && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SCNT_W'(1);
    end
    stall_d = (starve_d == STARVE_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_req_o  = stall_q & ~reset;
  assign chk_busy_1_o = ~reset & is_real_reg(chk_addr_1_i) & hit_1;
  assign chk_busy_2_o = ~reset & is_real_reg(chk_addr_2_i) & hit_2;

  a_no_wb_during_stall : assert property (
    @(posedge clk) disable iff (reset) stall_req_o |-> !wb_valid_i
  );

  a_no_ready_when_full : assert property (
    @(posedge clk) disable iff (reset) fifo_full |-> !ext_ready_o
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
// tb_rf_write_arbiter : directed + random bench against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  ext_addr;
  logic [31:0] ext_data;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr_1;
  logic [4:0]  chk_addr_2;
  logic        chk_busy_1;
  logic        chk_busy_2;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid_i   (wb_valid),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .ext_valid_i  (ext_valid),
    .ext_ready_o  (ext_ready),
    .ext_addr_i   (ext_addr),
    .ext_data_i   (ext_data),
    .stall_req_o  (stall_req),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .chk_addr_1_i (chk_addr_1),
    .chk_addr_2_i (chk_addr_2),
    .chk_busy_1_o (chk_busy_1),
    .chk_busy_2_o (chk_busy_2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending secondary writes in arrival order, and blocked-cycle count.
  logic [36:0] q[$];
  int          m_starve = 0;
  bit          m_stall  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i][36:32] == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit          e_ready, e_we, push, pop, was_empty;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    e_ready = !reset && (q.size() < DEPTH);
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    if (!reset) begin
      if (wb_valid) begin
        e_we   = (wb_addr != 5'd0);
        e_addr = wb_addr;
        e_data = wb_data;
      end else if (q.size() > 0) begin
        e_we   = 1'b1;
        e_addr = q[0][36:32];
        e_data = q[0][31:0];
      end
    end
    check("ext_ready", 32'(ext_ready), 32'(e_ready));
    check("rf_we", 32'(rf_we), 32'(e_we));
    if (reset || e_we || wb_valid) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check("rf_wdata", rf_wdata, e_data);
    end
    check("stall_req", 32'(stall_req), 32'(!reset && m_stall));
    check("chk_busy_1", 32'(chk_busy_1), 32'(!reset && m_busy(chk_addr_1)));
    check("chk_busy_2", 32'(chk_busy_2), 32'(!reset && m_busy(chk_addr_2)));
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      pop       = !wb_valid && !was_empty;
      push      = ext_valid && e_ready && (ext_addr != 5'd0);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({ext_addr, ext_data});
      if (pop || was_empty)                m_starve = 0;
      else if (wb_valid && m_starve < LIMIT) m_starve++;
      m_stall = (m_starve == LIMIT);
    end
    #1;
  endtask

  task automatic idle();
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    ext_valid = 1'b0;
    ext_addr  = '0;
    ext_data  = '0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
    #1 check("drained_we", 32'(rf_we), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    chk_addr_1 = '0;
    chk_addr_2 = '0;
    step();
    step();
    check("rst_ready", 32'(ext_ready), 32'(0));
    check("rst_we", 32'(rf_we), 32'(0));
    reset = 1'b0;

    // Idle pipeline: ext write to r8 shows up the next cycle.
    ext_valid = 1'b1; ext_addr = 5'd8; ext_data = 32'hDEADBEEF; chk_addr_1 = 5'd8;
    #1 check("s1_ready", 32'(ext_ready), 32'(1));
    step();
    ext_valid = 1'b0;
    #1;
    check("s1_we", 32'(rf_we), 32'(1));
    check("s1_addr", 32'(rf_waddr), 32'd8);
    check("s1_data", rf_wdata, 32'hDEADBEEF);
    check("s1_busy", 32'(chk_busy_1), 32'(1));
    step();
    #1 check("s1_busy_drop", 32'(chk_busy_1), 32'(0));

    // Continuous WB traffic starves r3 until a bubble is requested.
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = $urandom;
    ext_valid = 1'b1; ext_addr = 5'd3; ext_data = 32'h0000_0333; chk_addr_2 = 5'd3;
    step();
    ext_valid = 1'b0;
    for (int i = 0; i < 10 && !m_stall; i++) begin
      wb_data = $urandom;
      step();
    end
    check("s2_stall", 32'(stall_req), 32'(1));
    check("s2_busy", 32'(chk_busy_2), 32'(1));
    wb_valid = 1'b0;
    #1 check("s2_pop_addr", 32'(rf_waddr), 32'd3);
    step();
    #1 check("s2_stall_fall", 32'(stall_req), 32'(0));
    drain();

    // Three back-to-back ext writes against a depth-2 FIFO.
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = $urandom;
    ext_valid = 1'b1; ext_addr = 5'd10; ext_data = 32'hA;
    step();
    ext_addr = 5'd11; ext_data = 32'hB;
    step();
    ext_addr = 5'd12; ext_data = 32'hC;
    #1 check("s3_full", 32'(ext_ready), 32'(0));
    step();
    wb_valid = 1'b0;
    #1 check("s3_pop_first", 32'(rf_waddr), 32'd10);
    step();
    #1 check("s3_ready_back", 32'(ext_ready), 32'(1));
    step();
    ext_valid = 1'b0;
    drain();

    // Push and pop every cycle with one entry queued.
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = $urandom;
    ext_valid = 1'b1; ext_addr = 5'd20; ext_data = $urandom;
    step();
    wb_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ext_addr = 5'(21 + i);
      ext_data = $urandom;
      #1 check("s4_we", 32'(rf_we), 32'(1));
      step();
    end
    drain();

    // Writes targeting r0.
    ext_valid = 1'b1; ext_addr = 5'd0; ext_data = $urandom; chk_addr_1 = 5'd0;
    #1 check("s5_ready", 32'(ext_ready), 32'(1));
    step();
    ext_valid = 1'b0;
    #1 check("s5_ext_r0_we", 32'(rf_we), 32'(0));
    check("s5_busy_r0", 32'(chk_busy_1), 32'(0));
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = $urandom;
    #1 check("s5_wb_r0_we", 32'(rf_we), 32'(0));
    step();

    // Reset with two entries queued drops them.
    wb_addr = 5'd2; ext_valid = 1'b1; ext_addr = 5'd4; ext_data = $urandom; chk_addr_1 = 5'd4;
    step();
    ext_addr = 5'd5;
    step();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("s6_we", 32'(rf_we), 32'(0));
    check("s6_ready", 32'(ext_ready), 32'(1));
    check("s6_busy", 32'(chk_busy_1), 32'(0));
    step();

    // Randomized traffic; WB honours the bubble request as the pipeline would.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      wb_valid   = !m_stall && ($urandom_range(0, 99) < 60);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      ext_valid  = ($urandom_range(0, 99) < 50);
      ext_addr   = 5'($urandom_range(0, 7));
      ext_data   = $urandom;
      chk_addr_1 = 5'($urandom_range(0, 7));
      chk_addr_2 = 5'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
